// File: rtl/instr_fetch.sv
// instr_fetch: PC generation, 1-cycle synchronous imem read, 2-entry output queue to decode with redirect flush
// Optional feature macro: FETCH_PERF_EN adds saturating perf counters perf_fetched_o/perf_stalls_o/perf_flushes_o
module instr_fetch #(
   parameter int                 P_WIDTH  = 12,
   parameter int                 I_WIDTH  = 9,
   parameter logic [P_WIDTH-1:0] RESET_PC = '0,
   parameter logic [P_WIDTH-1:0] LAST_PC  = '1
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               start_i,
   output logic               imem_rd_o,
   output logic [P_WIDTH-1:0] imem_addr_o,
   input  logic [I_WIDTH-1:0] imem_data_i,
   input  logic               redir_valid_i,
   input  logic [P_WIDTH-1:0] redir_pc_i,
   output logic               inst_valid_o,
   input  logic               inst_ready_i,
   output logic [I_WIDTH-1:0] inst_o,
   output logic [P_WIDTH-1:0] inst_pc_o,
   output logic [P_WIDTH-1:0] link_pc_o,
`ifdef FETCH_PERF_EN
   output logic [15:0]        perf_fetched_o,
   output logic [15:0]        perf_stalls_o,
   output logic [15:0]        perf_flushes_o,
`endif
   output logic               done_o
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   typedef struct packed {
      logic [I_WIDTH-1:0] inst;
      logic [P_WIDTH-1:0] pc;
      logic [P_WIDTH-1:0] link;
   } entry_t;

   state_t             state_q;
   logic [P_WIDTH-1:0] pc_q, pc_d;
   logic [P_WIDTH-1:0] fpc_q, fpc_d;
   logic               fly_q, fly_d;
   logic [1:0]         occ_q, occ_d;
   entry_t             e0_q, e0_d, e1_q, e1_d, rsp;
   logic               done_q;
   logic               active, redir, flush, pop, issue;

   assign active       = (state_q == RUN) || (state_q == DRAIN);
   assign redir        = active && redir_valid_i;
   assign flush        = redir || start_i;
   assign pop          = inst_valid_o && inst_ready_i;
   assign issue        = (state_q == RUN) && !flush &&
                         (({1'b0, occ_q} + {2'b0, fly_q}) < (3'd2 + {2'b0, pop}));
   assign rsp          = {imem_data_i, fpc_q, fpc_q + P_WIDTH'(1)};
   assign imem_rd_o    = issue;
   assign imem_addr_o  = pc_q;
   assign inst_valid_o = occ_q != 2'd0;
   assign inst_o       = e0_q.inst;
   assign inst_pc_o    = e0_q.pc;
   assign link_pc_o    = e0_q.link;
   assign done_o       = done_q;

   // next PC, in-flight tracking and queue contents; a response is only pushed if its read was not flushed
   always_comb begin
      pc_d  = issue ? pc_q + P_WIDTH'(1) : pc_q;
      fpc_d = issue ? pc_q : fpc_q;
      fly_d = issue;
      occ_d = occ_q - {1'b0, pop} + {1'b0, fly_q};
      e0_d  = pop ? e1_q : e0_q;
      e1_d  = e1_q;
      if (fly_q && (occ_q - {1'b0, pop}) == 2'd0)
         e0_d = rsp;
      else if (fly_q)
         e1_d = rsp;
      if (flush) begin
         occ_d = 2'd0;
         fly_d = 1'b0;
         pc_d  = redir ? redir_pc_i : RESET_PC;
      end
   end

   // fetch FSM plus all datapath registers
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         fpc_q   <= '0;
         fly_q   <= 1'b0;
         occ_q   <= 2'd0;
         e0_q    <= '0;
         e1_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         fpc_q <= fpc_d;
         fly_q <= fly_d;
         occ_q <= occ_d;
         e0_q  <= e0_d;
         e1_q  <= e1_d;
         if (flush) begin
            state_q <= RUN;
            done_q  <= 1'b0;
         end else begin
            case (state_q)
               RUN:     state_q <= (issue && pc_q == LAST_PC) ? DRAIN : RUN;
               DRAIN: begin
                  if (occ_d == 2'd0 && !fly_d) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end
               end
               default: state_q <= state_q;
            endcase
         end
      end
   end

`ifdef FETCH_PERF_EN
   logic [15:0] fetched_q, stalls_q, flushes_q;

   assign perf_fetched_o = fetched_q;
   assign perf_stalls_o  = stalls_q;
   assign perf_flushes_o = flushes_q;

   // saturating event counters, cleared by reset or start
   always_ff @(posedge clk_i) begin
      if (reset_i || start_i) begin
         fetched_q <= '0;
         stalls_q  <= '0;
         flushes_q <= '0;
      end else begin
         if (pop && fetched_q != 16'hFFFF)
            fetched_q <= fetched_q + 16'd1;
         if (inst_valid_o && !inst_ready_i && stalls_q != 16'hFFFF)
            stalls_q <= stalls_q + 16'd1;
         if (redir && flushes_q != 16'hFFFF)
            flushes_q <= flushes_q + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed self-checking bench for instr_fetch (LAST_PC=8) with a behavioural instruction memory
module tb_instr_fetch;
   logic        clk = 1'b0;
   logic        reset, start, imem_rd, redir_valid, inst_valid, inst_ready, done;
   logic [11:0] imem_addr, redir_pc, inst_pc, link_pc;
   logic [8:0]  imem_data, inst;
`ifdef FETCH_PERF_EN
   logic [15:0] perf_fetched, perf_stalls, perf_flushes;
`endif
   int vectors = 0, miscompares = 0, bad_addr = 0, hs = 0;
   logic chk_addr = 1'b1;

   always #5 clk = ~clk;

   instr_fetch #(.P_WIDTH(12), .I_WIDTH(9), .RESET_PC(12'h000), .LAST_PC(12'h008)) dut (
      .clk_i(clk), .reset_i(reset), .start_i(start),
      .imem_rd_o(imem_rd), .imem_addr_o(imem_addr), .imem_data_i(imem_data),
      .redir_valid_i(redir_valid), .redir_pc_i(redir_pc),
      .inst_valid_o(inst_valid), .inst_ready_i(inst_ready),
      .inst_o(inst), .inst_pc_o(inst_pc), .link_pc_o(link_pc),
`ifdef FETCH_PERF_EN
      .perf_fetched_o(perf_fetched), .perf_stalls_o(perf_stalls), .perf_flushes_o(perf_flushes),
`endif
      .done_o(done));

   always @(posedge clk) if (imem_rd) imem_data <= imem_addr[8:0] ^ 9'h1A5;
   always @(posedge clk) if (start) hs <= 0; else if (inst_valid && inst_ready) hs <= hs + 1;
   always @(negedge clk) if (chk_addr && imem_rd && imem_addr > 12'h008) bad_addr++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic chk_slot(input string tag, input logic [11:0] pc);
      logic [8:0] d;
      d = pc[8:0] ^ 9'h1A5;
      chk({tag, "_valid"}, inst_valid, 1'b1);
      chk({tag, "_pc"}, inst_pc, pc);
      chk({tag, "_inst"}, inst, d);
      chk({tag, "_link"}, link_pc, pc + 12'd1);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; redir_valid = 1'b0; redir_pc = '0; inst_ready = 1'b1;
      step(); step();
      step(); reset = 1'b0; mid();
      chk("rst_valid", inst_valid, 1'b0);
      chk("rst_rd", imem_rd, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_inst", inst, 9'h000);
      chk("rst_pc", inst_pc, 12'h000);
      chk("rst_link", link_pc, 12'h000);
      chk("rst_addr", imem_addr, 12'h000);
      step(); start = 1'b1; mid();
      chk("s1_rd_idle", imem_rd, 1'b0);
      for (int k = 1; k <= 12; k++) begin
         step(); start = 1'b0; mid();
         if (k <= 9) begin
            chk("s1_rd", imem_rd, 1'b1);
            chk("s1_addr", imem_addr, 12'(k - 1));
         end else chk("s4_no_rd", imem_rd, 1'b0);
         if (k >= 3 && k <= 11) chk_slot("s1", 12'(k - 3));
         chk("s4_done", done, k == 12);
      end
      step(); mid();
      chk("s4_done_hold", done, 1'b1);
      chk("s4_valid_done", inst_valid, 1'b0);
      chk("s4_addr_le_last", bad_addr, 0);
      step(); start = 1'b1; mid();
      chk("s4_done_until_start", done, 1'b1);
      step(); start = 1'b0; mid();
      chk("s4_done_clr", done, 1'b0);
      chk("s4_rd", imem_rd, 1'b1);
      chk("s4_addr0", imem_addr, 12'h000);
      for (int k = 2; k <= 6; k++) begin
         step(); mid();
         if (k >= 3) chk_slot("s2_pre", 12'(k - 3));
      end
      for (int k = 7; k <= 11; k++) begin
         step(); inst_ready = 1'b0; mid();
         chk_slot("s2_hold", 12'h004);
         chk("s2_rd_stop", imem_rd, 1'b0);
      end
      step(); inst_ready = 1'b1; mid();
      chk_slot("s2_rel4", 12'h004);
      chk("s2_refill_addr", imem_addr, 12'h006);
      chk("s2_refill_rd", imem_rd, 1'b1);
      step(); redir_valid = 1'b1; redir_pc = 12'h100; mid();
      chk_slot("s2_rel5", 12'h005);
      chk("s3_rd_suppressed", imem_rd, 1'b0);
      chk("s2_addr_le_last", bad_addr, 0);
      chk_addr = 1'b0;
      step(); redir_valid = 1'b0; mid();
      chk("s3_flush_valid", inst_valid, 1'b0);
      chk("s3_rd", imem_rd, 1'b1);
      chk("s3_addr", imem_addr, 12'h100);
      step(); mid();
      chk("s3_killed_valid", inst_valid, 1'b0);
      chk("s3_addr1", imem_addr, 12'h101);
      step(); mid();
      chk_slot("s3_tgt", 12'h100);
      step(); mid();
      chk_slot("s3_tgt1", 12'h101);
`ifdef FETCH_PERF_EN
      chk("s6_stalls", perf_stalls, 16'd5);
      chk("s6_flushes", perf_flushes, 16'd1);
      chk("s6_fetched_bench", perf_fetched, 16'(hs));
      chk("s6_fetched", perf_fetched, 16'd7);
`endif
      step(); start = 1'b1; mid();
      chk("s5_restart_rd", imem_rd, 1'b0);
      chk("s5_prestart_valid", inst_valid, 1'b1);
      step(); start = 1'b0; mid();
      chk("s5_restart_valid", inst_valid, 1'b0);
      chk("s5_restart_addr", imem_addr, 12'h000);
      chk("s5_restart_rd1", imem_rd, 1'b1);
      step(); mid();
      chk("s5_addr1", imem_addr, 12'h001);
      step(); mid();
      chk_slot("s5_q0", 12'h000);
      chk("s5_addr2", imem_addr, 12'h002);
      step(); inst_ready = 1'b0; mid();
      chk_slot("s5_q1", 12'h001);
      chk("s5_full_rd", imem_rd, 1'b0);
      step(); mid();
      chk("s5_full_rd2", imem_rd, 1'b0);
      step(); inst_ready = 1'b1; reset = 1'b1; mid();
      chk_slot("s5_q1_rst", 12'h001);
      chk("s5_rd_rst", imem_rd, 1'b1);
      chk("s5_addr_rst", imem_addr, 12'h003);
      step(); reset = 1'b0; mid();
      chk("s5_valid", inst_valid, 1'b0);
      chk("s5_done", done, 1'b0);
      chk("s5_rd_idle", imem_rd, 1'b0);
      chk("s5_inst", inst, 9'h000);
      chk("s5_pc", inst_pc, 12'h000);
      chk("s5_link", link_pc, 12'h000);
      chk("s5_addr", imem_addr, 12'h000);
      step(); mid();
      chk("s5_stale_dropped", inst_valid, 1'b0);
`ifdef FETCH_PERF_EN
      chk("s5_perf_clr", perf_fetched, 16'd0);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
